// File: rtl/fetch_ctrl.sv
// Program-counter sequencer: IDLE/RUN/DONE control with sequential, branch, stall and halt steps.
// Optional retired-instruction counter is enabled by defining FETCH_INSN_CNT_EN.
module fetch_ctrl #(
  parameter int D          = 10,
  parameter int START_ADDR = 0
`ifdef FETCH_INSN_CNT_EN
  ,
  parameter int CNT_W      = 16
`endif
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         start,
  input  logic         stall,
  input  logic         halt,
  input  logic         branch_en,
  input  logic         branch_rel,
  input  logic [D-1:0] target,
  output logic [D-1:0] prog_ctr,
  output logic         busy,
`ifdef FETCH_INSN_CNT_EN
  output logic [CNT_W-1:0] insn_cnt,
`endif
  output logic         done
);

  localparam logic [D-1:0] START_PC = D'(START_ADDR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic         retire;
  logic         launch;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    retire  = 1'b0;
    launch  = 1'b0;
    unique case (state_q)
      IDLE: begin
        pc_d = START_PC;
        if (start) begin
          state_d = RUN;
          launch  = 1'b1;
        end
      end
      RUN: begin
        if (stall) begin
          pc_d = pc_q;
        end else if (halt) begin
          state_d = DONE;
          retire  = 1'b1;
        end else if (branch_en) begin
          retire = 1'b1;
          // Relative add wraps mod 2**D, so two's-complement offsets need no sign handling.
          pc_d   = branch_rel ? (pc_q + target) : target;
        end else begin
          retire = 1'b1;
          pc_d   = pc_q + D'(1);
        end
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = START_PC;
          launch  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = START_PC;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign prog_ctr = pc_q;
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);

`ifdef FETCH_INSN_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (launch) begin
      cnt_d = '0;
    end else if (retire && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign insn_cnt = cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt = launch ^ retire;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl; counter checks are active when FETCH_INSN_CNT_EN is defined.
module tb_fetch_ctrl;

  localparam int D = 10;

  logic         Clk = 1'b0;
  logic         Reset, start, stall, halt, branch_en, branch_rel;
  logic [D-1:0] target;
  logic [D-1:0] prog_ctr;
  logic         busy, done;
`ifdef FETCH_INSN_CNT_EN
  logic [3:0]   insn_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  fetch_ctrl #(
    .D(D),
    .START_ADDR(0)
`ifdef FETCH_INSN_CNT_EN
    ,
    .CNT_W(4)
`endif
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .start(start),
    .stall(stall),
    .halt(halt),
    .branch_en(branch_en),
    .branch_rel(branch_rel),
    .target(target),
    .prog_ctr(prog_ctr),
    .busy(busy),
`ifdef FETCH_INSN_CNT_EN
    .insn_cnt(insn_cnt),
`endif
    .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic st(input string tag, input logic [D-1:0] pc, input logic b, input logic dn);
    chk({tag, ".pc"}, 32'(prog_ctr), 32'(pc));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(dn));
  endtask

  task automatic cnt(input string tag, input int exp);
`ifdef FETCH_INSN_CNT_EN
    chk({tag, ".cnt"}, 32'(insn_cnt), 32'(exp));
`endif
  endtask

  task automatic br(input logic rel, input logic [D-1:0] t);
    branch_en = 1'b1; branch_rel = rel; target = t;
    step();
    branch_en = 1'b0; branch_rel = 1'b0; target = '0;
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; stall = 1'b0; halt = 1'b0;
    branch_en = 1'b0; branch_rel = 1'b0; target = '0;
    step();
    step();
    st("reset", 0, 0, 0);
    cnt("reset", 0);
    Reset = 1'b0;
    step();
    st("idle_hold", 0, 0, 0);

    // Sequential run from 0, halt at 5
    start = 1'b1;
    step();
    start = 1'b0;
    st("start", 0, 1, 0);
    for (int i = 1; i <= 5; i++) step();
    st("seq5", 5, 1, 0);
    halt = 1'b1;
    step();
    halt = 1'b0;
    st("halt5", 5, 0, 1);
    cnt("halt5", 6);
    step();
    st("done_hold", 5, 0, 1);

    // Restart from DONE, start held during RUN
    start = 1'b1;
    step();
    st("restart", 0, 1, 0);
    cnt("restart", 0);
    step();
    start = 1'b0;
    st("start_ignored", 1, 1, 0);

    // Branches
    br(1'b0, 10'd10);
    st("abs10", 10, 1, 0);
    br(1'b1, 10'h3FC);
    st("rel_m4", 6, 1, 0);
    br(1'b0, 10'd300);
    st("abs300", 300, 1, 0);
    br(1'b0, 10'd1022);
    br(1'b1, 10'd3);
    st("rel_wrap", 1, 1, 0);
    br(1'b0, 10'd1023);
    step();
    st("seq_wrap", 0, 1, 0);

    // Stall dominates halt and branch; halt then beats branch
    br(1'b0, 10'd8);
    cnt("pre_stall", 9);
    stall = 1'b1; halt = 1'b1; branch_en = 1'b1; target = 10'd77;
    for (int i = 0; i < 3; i++) step();
    st("stall", 8, 1, 0);
    cnt("stall", 9);
    stall = 1'b0;
    step();
    halt = 1'b0; branch_en = 1'b0; target = '0;
    st("halt_vs_br", 8, 0, 1);
    cnt("halt_vs_br", 10);

    // Reset mid-run at 37
    start = 1'b1;
    step();
    start = 1'b0;
    br(1'b0, 10'd37);
    st("pc37", 37, 1, 0);
    Reset = 1'b1; start = 1'b1; branch_en = 1'b1; target = 10'd5;
    step();
    st("reset_mid", 0, 0, 0);
    cnt("reset_mid", 0);
    Reset = 1'b0; start = 1'b0; branch_en = 1'b0; target = '0;
    step();
    st("post_reset", 0, 0, 0);

    // Long unstalled run: counter saturates at 15
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) step();
    st("run20", 20, 1, 0);
    cnt("sat", 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
